// File: rtl/iod_ddrrx4_word_align.sv
// iod_ddrrx4_word_align
// Fabric-side word aligner for the 4:1 DDR forwarded-clock receive link.
// Watches the registered IOD word for the training pattern, pulses RX_BIT_SLIP
// until the pattern sits at the right bit position, then reports lock.
// Received data is passed through with one register of latency.
//
// Optional feature macro: IOD_RX_LOSS_OF_LOCK_EN
//   When defined, LOCKED monitors the training pattern while TRAIN_EN is high
//   and drops back into the search after LOL_THRESH consecutive bad words,
//   pulsing LOCK_LOST. When undefined, LOCKED holds and LOCK_LOST stays 0.
module iod_ddrrx4_word_align #(
  parameter logic [3:0] TRAIN_PATTERN = 4'b1100,
  parameter int         MATCH_CNT     = 16,
  parameter int         SLIP_WAIT     = 8,
  parameter int         MAX_SLIPS     = 8,
  parameter int         LOL_THRESH    = 4
) (
  input  logic       FAB_CLK,
  input  logic       RX_SYNC_RST,
  input  logic [3:0] RX_DATA,
  input  logic       ALIGN_START,
  input  logic       TRAIN_EN,
  output logic       RX_BIT_SLIP,
  output logic [3:0] RX_DATA_OUT,
  output logic       ALIGN_DONE,
  output logic       ALIGN_FAIL,
  output logic [3:0] SLIP_COUNT,
  output logic       LOCK_LOST
);

  // Counter widths follow the parameter ranges so nothing can wrap.
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CNT - 1);
  localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
  localparam logic [WW-1:0] WAIT_LOAD  = WW'(SLIP_WAIT);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [3:0]    SLIP_MAX   = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic [3:0]    slip_cnt;
  logic [3:0]    slip_nxt;
  logic          lost_nxt;
  logic          do_restart;
  logic          rx_match;
  logic [3:0]    rx_p0;

`ifdef IOD_RX_LOSS_OF_LOCK_EN
  localparam int            LW       = $clog2(LOL_THRESH + 1);
  localparam logic [LW-1:0] LOL_LAST = LW'(LOL_THRESH - 1);
  localparam logic [LW-1:0] LOL_ONE  = LW'(1);

  logic [LW-1:0] lol_cnt;
  logic [LW-1:0] lol_nxt;
`else
  // Loss-of-lock monitoring is compiled out; these inputs are intentionally ignored.
  localparam int unused_lol_thresh = LOL_THRESH;
  logic          unused_train_en;
  assign unused_train_en = TRAIN_EN;
`endif

  // Saturating slip counter: the count can never pass MAX_SLIPS.
  function automatic logic [3:0] slip_inc(input logic [3:0] cnt);
    if (cnt >= SLIP_MAX) begin
      return SLIP_MAX;
    end
    return cnt + 4'd1;
  endfunction

  assign rx_match = (rx_p0 == TRAIN_PATTERN);

  // Next-state and counter update for the alignment search.
  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    wait_nxt   = wait_cnt;
    slip_nxt   = slip_cnt;
    lost_nxt   = 1'b0;
    do_restart = 1'b0;
`ifdef IOD_RX_LOSS_OF_LOCK_EN
    lol_nxt    = '0;
`endif
    case (state)
      ST_IDLE: begin
        if (ALIGN_START) begin
          do_restart = 1'b1;
        end
      end
      ST_CHECK: begin
        if (rx_match) begin
          if (match_cnt == MATCH_LAST) begin
            match_nxt = '0;
            state_nxt = ST_LOCKED;
          end else begin
            match_nxt = match_cnt + MATCH_ONE;
          end
        end else begin
          match_nxt = '0;
          if (slip_cnt >= SLIP_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        slip_nxt  = slip_inc(slip_cnt);
        wait_nxt  = WAIT_LOAD;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // The IOD needs time to apply the slip before data is trusted again.
        if (wait_cnt <= WAIT_ONE) begin
          wait_nxt  = '0;
          match_nxt = '0;
          state_nxt = ST_CHECK;
        end else begin
          wait_nxt = wait_cnt - WAIT_ONE;
        end
      end
      ST_LOCKED: begin
        if (ALIGN_START) begin
          do_restart = 1'b1;
        end
`ifdef IOD_RX_LOSS_OF_LOCK_EN
        else if (TRAIN_EN && !rx_match) begin
          if (lol_cnt == LOL_LAST) begin
            lost_nxt   = 1'b1;
            do_restart = 1'b1;
          end else begin
            lol_nxt = lol_cnt + LOL_ONE;
          end
        end
`endif
      end
      ST_FAIL: begin
        if (ALIGN_START) begin
          do_restart = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A (re)start always begins a fresh search from zero.
    if (do_restart) begin
      state_nxt = ST_CHECK;
      match_nxt = '0;
      wait_nxt  = '0;
      slip_nxt  = '0;
    end
  end

  // State register and search counters.
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
      wait_cnt  <= '0;
      slip_cnt  <= '0;
`ifdef IOD_RX_LOSS_OF_LOCK_EN
      lol_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      wait_cnt  <= wait_nxt;
      slip_cnt  <= slip_nxt;
`ifdef IOD_RX_LOSS_OF_LOCK_EN
      lol_cnt   <= lol_nxt;
`endif
    end
  end

  // Status outputs, registered one cycle behind the state they report.
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      RX_BIT_SLIP <= 1'b0;
      ALIGN_DONE  <= 1'b0;
      ALIGN_FAIL  <= 1'b0;
      LOCK_LOST   <= 1'b0;
    end else begin
      RX_BIT_SLIP <= (state == ST_SLIP);
      ALIGN_DONE  <= (state == ST_LOCKED);
      ALIGN_FAIL  <= (state == ST_FAIL);
      LOCK_LOST   <= lost_nxt;
    end
  end

  // Stage p0: capture of the IOD word; this is both the compare point and the pass-through.
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      rx_p0 <= '0;
    end else begin
      rx_p0 <= RX_DATA;
    end
  end

  assign RX_DATA_OUT = rx_p0;
  assign SLIP_COUNT  = slip_cnt;

endmodule

// File: tb/tb_iod_ddrrx4_word_align.sv
// Bench for iod_ddrrx4_word_align: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the aligner.
`timescale 1ns/1ps
module tb_iod_ddrrx4_word_align;

  localparam logic [3:0] PAT   = 4'b1100;
  localparam int         MATCH = 16;
  localparam int         SWAIT = 8;
  localparam int         MAXS  = 8;
  localparam int         LOLT  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       train_en;
  logic [3:0] rx_data;
  logic       slip;
  logic [3:0] dout;
  logic       done;
  logic       fail;
  logic [3:0] scnt;
  logic       lost;

  // IOD stand-in: the link repeats PAT, the IOD word is PAT rotated left by
  // iod_off; raw_mode replaces it with an arbitrary word; corrupt flips bits.
  logic       raw_mode;
  logic [3:0] raw_word;
  logic [3:0] corrupt;
  int         iod_off;

  function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
    logic [3:0] r;
    r = w;
    for (int i = 0; i < (n % 4); i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  assign rx_data = (raw_mode ? raw_word : rotl(PAT, iod_off)) ^ corrupt;

  iod_ddrrx4_word_align #(
    .TRAIN_PATTERN(PAT),
    .MATCH_CNT    (MATCH),
    .SLIP_WAIT    (SWAIT),
    .MAX_SLIPS    (MAXS),
    .LOL_THRESH   (LOLT)
  ) dut (
    .FAB_CLK    (clk),
    .RX_SYNC_RST(rst),
    .RX_DATA    (rx_data),
    .ALIGN_START(start),
    .TRAIN_EN   (train_en),
    .RX_BIT_SLIP(slip),
    .RX_DATA_OUT(dout),
    .ALIGN_DONE (done),
    .ALIGN_FAIL (fail),
    .SLIP_COUNT (scnt),
    .LOCK_LOST  (lost)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: searching/locked/failed flags, run of matches,
  // settle time left after a slip decision, slips issued, bad-word run.
  bit         m_srch   = 1'b0;
  bit         m_lock   = 1'b0;
  bit         m_fail   = 1'b0;
  int         m_run    = 0;
  int         m_settle = 0;
  int         m_slips  = 0;
  int         m_bad    = 0;
  logic [3:0] m_rq     = 4'h0;
  logic       e_slip   = 1'b0;
  logic       e_done   = 1'b0;
  logic       e_fail   = 1'b0;
  logic       e_lost   = 1'b0;
  logic [3:0] e_cnt    = 4'h0;
  logic [3:0] e_dout   = 4'h0;

  // Slip pulse monitor for the directed scenarios.
  int cyc       = 0;
  int pulses    = 0;
  int last_rise = -1;
  int min_gap   = 1000;
  bit dbl       = 1'b0;
  bit prev_slip = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_restart();
    m_srch   = 1'b1;
    m_lock   = 1'b0;
    m_fail   = 1'b0;
    m_run    = 0;
    m_settle = 0;
    m_slips  = 0;
    m_bad    = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    if (rst) begin
      m_srch = 1'b0; m_lock = 1'b0; m_fail = 1'b0;
      m_run = 0; m_settle = 0; m_slips = 0; m_bad = 0;
      e_slip = 1'b0; e_done = 1'b0; e_fail = 1'b0; e_lost = 1'b0;
      e_cnt = 4'h0; e_dout = 4'h0; m_rq = 4'h0;
    end else begin
      e_slip = (m_settle == SWAIT + 1);
      e_done = m_lock;
      e_fail = m_fail;
      e_lost = 1'b0;
      e_dout = rx_data;
      if (!m_srch) begin
        if (start) m_restart();
`ifdef IOD_RX_LOSS_OF_LOCK_EN
        else if (m_lock) begin
          if (!train_en || m_rq == PAT) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == LOLT) begin
              e_lost = 1'b1;
              m_restart();
            end
          end
        end
`endif
      end else if (m_settle > 0) begin
        if (m_settle == SWAIT + 1) m_slips++;
        m_settle--;
      end else if (m_rq == PAT) begin
        m_run++;
        if (m_run == MATCH) begin
          m_srch = 1'b0;
          m_lock = 1'b1;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
        if (m_slips == MAXS) begin
          m_srch = 1'b0;
          m_fail = 1'b1;
        end else begin
          m_settle = SWAIT + 1;
        end
      end
      e_cnt = 4'(m_slips);
      m_rq  = rx_data;
    end
  endtask

  // One clock: model update, compare after the edge, IOD reacts at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("rx_bit_slip", 32'(slip), 32'(e_slip));
    chk("rx_data_out", 32'(dout), 32'(e_dout));
    chk("align_done",  32'(done), 32'(e_done));
    chk("align_fail",  32'(fail), 32'(e_fail));
    chk("slip_count",  32'(scnt), 32'(e_cnt));
    chk("lock_lost",   32'(lost), 32'(e_lost));
    cyc++;
    if (slip === 1'b1) begin
      if (prev_slip) dbl = 1'b1;
      else begin
        if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
        last_rise = cyc;
        pulses++;
      end
    end
    prev_slip = (slip === 1'b1);
    @(negedge clk);
    if (slip === 1'b1) iod_off = (iod_off + 1) % 4;
  endtask

  task automatic mon_clear();
    pulses    = 0;
    last_rise = -1;
    min_gap   = 1000;
    dbl       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; corrupt = 4'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // kind 0: ALIGN_DONE, 1: ALIGN_FAIL, 2: n slip pulses seen, 3: LOCK_LOST
  task automatic wait_for(input int kind, input int bound, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      case (kind)
        0: ok = (done === 1'b1);
        1: ok = (fail === 1'b1);
        2: ok = (pulses >= n);
        default: ok = (lost === 1'b1);
      endcase
    end
  endtask

  initial begin
    bit ok;
    int seen;
    int mode;
    int len;
    rst = 1'b1; start = 1'b0; train_en = 1'b1;
    raw_mode = 1'b0; raw_word = 4'h0; corrupt = 4'h0; iod_off = 0;

    // Reset state
    tick(); tick();
    chk("rst_slip", 32'(slip), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_scnt", 32'(scnt), 32'd0);
    chk("rst_lost", 32'(lost), 32'd0);
    rst = 1'b0;
    tick(); tick();

    // 1: aligned input, lock exactly after edge MATCH+1
    mon_clear();
    pulse_start();
    repeat (MATCH) tick();
    chk("t1_done_edge16", 32'(done), 32'd0);
    tick();
    chk("t1_done_edge17", 32'(done), 32'd1);
    chk("t1_scnt", 32'(scnt), 32'd0);
    chk("t1_pulses", 32'(pulses), 32'd0);

    // 2: two-bit offset needs two spaced slips
    do_reset();
    iod_off = 2;
    tick(); tick();
    mon_clear();
    pulse_start();
    wait_for(0, 300, 0, ok);
    chk("t2_lock_timeout", 32'(ok), 32'd1);
    chk("t2_pulses", 32'(pulses), 32'd2);
    chk("t2_gap_ge_10", 32'(min_gap >= SWAIT + 2), 32'd1);
    chk("t2_single_cycle", 32'(dbl), 32'd0);
    chk("t2_scnt", 32'(scnt), 32'd2);

    // 3: all-zero data exhausts the slip budget
    do_reset();
    raw_mode = 1'b1; raw_word = 4'h0;
    tick(); tick();
    mon_clear();
    pulse_start();
    wait_for(1, 400, 0, ok);
    chk("t3_fail_timeout", 32'(ok), 32'd1);
    chk("t3_pulses", 32'(pulses), 32'd8);
    chk("t3_scnt", 32'(scnt), 32'd8);
    chk("t3_done", 32'(done), 32'd0);
    pulse_start();
    chk("t3_restart_scnt", 32'(scnt), 32'd0);

    // 4: one corrupted word at the 10th match, no IOD rotation effect
    do_reset();
    raw_mode = 1'b1; raw_word = PAT;
    tick(); tick();
    mon_clear();
    pulse_start();
    repeat (8) tick();
    corrupt = 4'hF;
    tick();
    corrupt = 4'h0;
    repeat (26) tick();
    chk("t4_done_edge35", 32'(done), 32'd0);
    tick();
    chk("t4_done_edge36", 32'(done), 32'd1);
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_scnt", 32'(scnt), 32'd1);

    // 5: reset while waiting after the third slip, then realign
    do_reset();
    raw_mode = 1'b0; iod_off = 1;
    tick(); tick();
    mon_clear();
    pulse_start();
    wait_for(2, 300, 3, ok);
    chk("t5_slips_timeout", 32'(ok), 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5_slip", 32'(slip), 32'd0);
    chk("t5_dout", 32'(dout), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_fail", 32'(fail), 32'd0);
    chk("t5_scnt", 32'(scnt), 32'd0);
    chk("t5_lost", 32'(lost), 32'd0);
    rst = 1'b0;
    tick();
    mon_clear();
    pulse_start();
    wait_for(0, 100, 0, ok);
    chk("t5_relock_timeout", 32'(ok), 32'd1);
    chk("t5_relock_scnt", 32'(scnt), 32'd0);

`ifdef IOD_RX_LOSS_OF_LOCK_EN
    // 6: loss of lock with TRAIN_EN high, held lock with TRAIN_EN low
    do_reset();
    raw_mode = 1'b0; iod_off = 0; train_en = 1'b1;
    tick();
    pulse_start();
    wait_for(0, 100, 0, ok);
    chk("t6_lock_timeout", 32'(ok), 32'd1);
    corrupt = 4'hF;
    repeat (LOLT) tick();
    corrupt = 4'h0;
    wait_for(3, 10, 0, ok);
    chk("t6_lost_timeout", 32'(ok), 32'd1);
    tick();
    chk("t6_done_dropped", 32'(done), 32'd0);
    wait_for(0, 100, 0, ok);
    chk("t6_relock_timeout", 32'(ok), 32'd1);
    train_en = 1'b0;
    corrupt  = 4'hF;
    repeat (LOLT) tick();
    corrupt = 4'h0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (lost === 1'b1) seen++;
    end
    chk("t6_hold_done", 32'(done), 32'd1);
    chk("t6_hold_lost", 32'(seen), 32'd0);
    train_en = 1'b1;
`endif

    // Randomized traffic: clean link, corrupted link, raw words, random resets
    for (int s = 0; s < 40; s++) begin
      mode     = int'($urandom_range(0, 3));
      raw_mode = (mode == 2);
      raw_word = ($urandom_range(0, 1) == 0) ? PAT : 4'($urandom);
      iod_off  = int'($urandom_range(0, 3));
      train_en = 1'($urandom);
      len      = int'($urandom_range(60, 220));
      for (int c = 0; c < len; c++) begin
        start   = (c == 0) || ($urandom_range(0, 19) == 0);
        corrupt = (mode == 1 && $urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        if (mode == 2 && $urandom_range(0, 7) == 0) raw_word = 4'($urandom);
        rst     = (mode == 3 && $urandom_range(0, 49) == 0);
        tick();
      end
    end
    rst = 1'b0; start = 1'b0; corrupt = 4'h0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
